// File: rtl/reg_serial_reader_if.sv
// Handshake bundle for reg_serial_reader.
//   master : the reader side. It takes Start/Abort/Din/Ser_Ready and drives the
//            serial bit (Ser_Valid/Ser_Data/Ser_Last) plus the status outputs
//            (Busy/Done/Bits_Sent).
//   slave  : the controller/sink side. It drives the request and ready inputs
//            and observes everything the reader produces.
interface reg_serial_reader_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             Start;
  logic             Abort;
  logic [WIDTH-1:0] Din;
  logic             Ser_Ready;
  logic             Ser_Valid;
  logic             Ser_Data;
  logic             Ser_Last;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Bits_Sent;

  modport master (
    input  Start, Abort, Din, Ser_Ready,
    output Ser_Valid, Ser_Data, Ser_Last, Busy, Done, Bits_Sent
  );

  modport slave (
    output Start, Abort, Din, Ser_Ready,
    input  Ser_Valid, Ser_Data, Ser_Last, Busy, Done, Bits_Sent
  );
endinterface

// File: rtl/reg_serial_reader.sv
// Serial read-out of a parallel register, MSB first, over a per-bit
// valid/ready handshake.
//
// Start (sampled in IDLE) snapshots Din into a shadow register, so the source
// register may change freely while the transfer is in flight. Each accepted
// bit (Ser_Valid & Ser_Ready) shifts the shadow left. Abort (sampled in SHIFT)
// drops back to IDLE without a Done pulse. A bit accepted on the same edge as
// Abort still counts in Bits_Sent.
//
// Ports
//   Clk, Reset : rising-edge clock; synchronous active-high reset
//   bus        : reg_serial_reader_if.master
//                (Start/Abort/Din/Ser_Ready in; Ser_Valid/Ser_Data/Ser_Last,
//                 Busy/Done/Bits_Sent out)
//
// Every output is a flop. None has a combinational path from an input.
module reg_serial_reader #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                 Clk,
  input logic                 Reset,
  reg_serial_reader_if.master bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] bits_sent;
  logic             ser_valid, ser_data, ser_last, busy, done;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      shadow    <= '0;
      idx       <= '0;
      bits_sent <= '0;
      ser_valid <= 1'b0;
      ser_data  <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.Start) begin
            state     <= SHIFT;
            shadow    <= bus.Din;
            idx       <= IDX_W'(WIDTH - 1);
            bits_sent <= '0;
            ser_valid <= 1'b1;
            ser_data  <= bus.Din[WIDTH-1];
            // WIDTH >= 2, so the first bit is never the last one.
            ser_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end

        SHIFT: begin
          // A bit offered while the sink is ready counts as sent, even when
          // Abort lands on the same edge.
          if (bus.Ser_Ready && bits_sent != CNT_W'(WIDTH))
            bits_sent <= bits_sent + 1'b1;

          if (bus.Abort) begin
            state     <= IDLE;
            ser_valid <= 1'b0;
            ser_data  <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
          end else if (bus.Ser_Ready) begin
            shadow <= shadow << 1;
            if (ser_last) begin
              state     <= DONE;
              ser_valid <= 1'b0;
              ser_data  <= 1'b0;
              ser_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx      <= idx - 1'b1;
              // The next bit is the bit that sits below the MSB now.
              ser_data <= shadow[WIDTH-2];
              ser_last <= (idx == IDX_W'(1));
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          ser_valid <= 1'b0;
          ser_data  <= 1'b0;
          ser_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ser_Valid = ser_valid;
  assign bus.Ser_Data  = ser_data;
  assign bus.Ser_Last  = ser_last;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.Bits_Sent = bits_sent;
endmodule

// File: tb/tb_reg_serial_reader.sv
module tb_reg_serial_reader;
  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic Clk, Reset;
  reg_serial_reader_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  reg_serial_reader #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level reference: one word in flight, k bits accepted so far.
  bit          m_active, m_done;
  int          m_k;
  logic [W-1:0] m_word;

  // Observed traffic.
  logic [W-1:0] rx;
  int          rx_n, n_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, st, ab, input logic [W-1:0] d, input bit rdy);
    if (rst) begin
      m_active = 0; m_done = 0; m_k = 0; m_word = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (rdy && m_k < W) m_k++;
      if (ab) m_active = 0;
      else if (rdy && m_k == W) begin m_active = 0; m_done = 1; end
    end else if (st) begin
      m_active = 1; m_word = d; m_k = 0;
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, then check all outputs.
  task automatic cycle(input bit rst, st, ab, input logic [W-1:0] d, input bit rdy);
    Reset = rst; bus.Start = st; bus.Abort = ab; bus.Din = d; bus.Ser_Ready = rdy;
    if (!rst && bus.Ser_Valid === 1'b1 && rdy) begin
      rx = {rx[W-2:0], bus.Ser_Data};
      rx_n++;
    end
    @(posedge Clk);
    model_step(rst, st, ab, d, rdy);
    #1;
    chk("valid", 32'(bus.Ser_Valid), 32'(m_active));
    chk("data",  32'(bus.Ser_Data),  m_active ? 32'(m_word[W-1-m_k]) : 32'd0);
    chk("last",  32'(bus.Ser_Last),  32'(m_active && m_k == W-1));
    chk("busy",  32'(bus.Busy),      32'(m_active || m_done));
    chk("done",  32'(bus.Done),      32'(m_done));
    chk("bits",  32'(bus.Bits_Sent), 32'(m_k));
    if (bus.Done === 1'b1) n_done++;
  endtask

  task automatic clr_obs();
    rx = '0; rx_n = 0; n_done = 0;
  endtask

  typedef struct {
    bit          rst, st, ab;
    logic [15:0] din;
    bit          rdy;
    bit          valid, data, last, busy, done;
    int          bits;
  } vec_t;

  vec_t tbl[10];

  initial begin
    Reset = 1'b1; bus.Start = 1'b0; bus.Abort = 1'b0; bus.Din = '0; bus.Ser_Ready = 1'b0;
    clr_obs();

    //              rst st ab  din       rdy  v  d  l  b  dn bits
    tbl[0] = '{1, 1, 0, 16'hFFFF, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 16'hFFFF, 1, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 16'hA5C3, 1, 1, 1, 0, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 16'hFFFF, 1, 1, 0, 0, 1, 0, 1};
    tbl[4] = '{0, 0, 0, 16'hFFFF, 0, 1, 0, 0, 1, 0, 1};
    tbl[5] = '{0, 1, 0, 16'h0000, 0, 1, 0, 0, 1, 0, 1};
    tbl[6] = '{0, 0, 0, 16'h0000, 1, 1, 1, 0, 1, 0, 2};
    tbl[7] = '{0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 2};
    tbl[8] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 2};
    tbl[9] = '{1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0};

    // Table: reset with Start high, a stalled transfer, ignored Start, Abort.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].rst, tbl[i].st, tbl[i].ab, tbl[i].din, tbl[i].rdy);
      chk($sformatf("tbl_valid[%0d]", i), 32'(bus.Ser_Valid), 32'(tbl[i].valid));
      chk($sformatf("tbl_data[%0d]", i),  32'(bus.Ser_Data),  32'(tbl[i].data));
      chk($sformatf("tbl_last[%0d]", i),  32'(bus.Ser_Last),  32'(tbl[i].last));
      chk($sformatf("tbl_busy[%0d]", i),  32'(bus.Busy),      32'(tbl[i].busy));
      chk($sformatf("tbl_done[%0d]", i),  32'(bus.Done),      32'(tbl[i].done));
      chk($sformatf("tbl_bits[%0d]", i),  32'(bus.Bits_Sent), 32'(tbl[i].bits));
    end

    // Full-rate transfer: Done on the 17th cycle after the accepting edge.
    clr_obs();
    cycle(0, 1, 0, 16'hA5C3, 1);
    for (int i = 1; i <= W; i++) begin
      chk("a5c3_last", 32'(bus.Ser_Last), 32'(i == W));
      cycle(0, 0, 0, 16'h0000, 1);
    end
    chk("a5c3_done_cycle", 32'(bus.Done), 32'd1);
    chk("a5c3_bits", 32'(bus.Bits_Sent), 32'(W));
    cycle(0, 0, 0, 16'h0000, 1);
    chk("a5c3_word", 32'(rx), 32'hA5C3);
    chk("a5c3_ndone", 32'(n_done), 32'd1);

    // Random stalls on 8001.
    clr_obs();
    cycle(0, 1, 0, 16'h8001, 0);
    for (int i = 0; i < 200 && n_done == 0; i++)
      cycle(0, 0, 0, 16'h0000, bit'($urandom_range(0, 2) == 0));
    cycle(0, 0, 0, 16'h0000, 0);
    chk("8001_word", 32'(rx), 32'h8001);
    chk("8001_ndone", 32'(n_done), 32'd1);

    // Din changes and a re-pulsed Start during a transfer have no effect.
    clr_obs();
    cycle(0, 1, 0, 16'h1234, 1);
    for (int i = 1; i < 30; i++)
      cycle(0, i == 5, 0, 16'hFFFF, 1);
    chk("1234_word", 32'(rx), 32'h1234);
    chk("1234_ndone", 32'(n_done), 32'd1);
    chk("1234_nbits", 32'(rx_n), 32'(W));

    // Abort after 5 bits, then a clean transfer.
    clr_obs();
    cycle(0, 1, 0, 16'hF0F0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 16'h0000, 1);
    cycle(0, 0, 1, 16'h0000, 0);
    chk("abort_valid", 32'(bus.Ser_Valid), 32'd0);
    chk("abort_bits", 32'(bus.Bits_Sent), 32'd5);
    cycle(0, 0, 0, 16'h0000, 0);
    chk("abort_ndone", 32'(n_done), 32'd0);
    clr_obs();
    cycle(0, 1, 0, 16'h0F0F, 1);
    for (int i = 0; i < W + 1; i++) cycle(0, 0, 0, 16'h0000, 1);
    chk("0f0f_word", 32'(rx), 32'h0F0F);
    chk("0f0f_ndone", 32'(n_done), 32'd1);

    // Reset mid-transfer after 9 bits.
    clr_obs();
    cycle(0, 1, 0, 16'hBEEF, 1);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 16'h0000, 1);
    chk("pre_rst_bits", 32'(bus.Bits_Sent), 32'd9);
    cycle(1, 0, 0, 16'h0000, 1);
    chk("rst_bits", 32'(bus.Bits_Sent), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    cycle(0, 0, 0, 16'h0000, 1);
    chk("rst_ndone", 32'(n_done), 32'd0);

    // Abort coincident with the last transfer: bit counts, no Done.
    clr_obs();
    cycle(0, 1, 0, 16'h5A5A, 1);
    for (int i = 0; i < W - 1; i++) cycle(0, 0, 0, 16'h0000, 1);
    chk("al_last", 32'(bus.Ser_Last), 32'd1);
    cycle(0, 0, 1, 16'h0000, 1);
    chk("al_bits", 32'(bus.Bits_Sent), 32'(W));
    chk("al_valid", 32'(bus.Ser_Valid), 32'd0);
    cycle(0, 0, 0, 16'h0000, 0);
    chk("al_ndone", 32'(n_done), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      cycle(bit'($urandom_range(0, 199) == 0), bit'($urandom_range(0, 3) == 0),
            bit'($urandom_range(0, 39) == 0), W'($urandom), bit'($urandom_range(0, 2) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_serial_reader.md
Name: reg_serial_reader

Overview:
- Reads a parallel value already latched in a datapath register (e.g. a 16-bit MDR/IR-style register) and streams it out MSB-first over a per-bit valid/ready serial handshake.
- It is the read-out end of the register path: registers are loaded in parallel, and this block unloads them serially to a debug/host link.
- It captures a shadow copy on Start, so the source register may change while the transfer is in progress.

Parameters:
- WIDTH, 16, number of bits captured and shifted out per transfer (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of the Bits_Sent counter output.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a transfer; sampled only in IDLE.
- Abort  input  1  cancel the transfer in progress; sampled only in SHIFT.
- Din  input  WIDTH  parallel value from the source register; captured when Start is accepted.
- Ser_Ready  input  1  sink is ready to accept the current bit.
- Ser_Valid  output  1  current bit on Ser_Data is valid.
- Ser_Data  output  1  current serial bit, MSB first.
- Ser_Last  output  1  current bit is bit 0 (the final bit).
- Busy  output  1  high in SHIFT and DONE.
- Done  output  1  one-cycle pulse after a completed (non-aborted) transfer.
- Bits_Sent  output  CNT_W  number of bits accepted by the sink in the current or most recent transfer.

Behaviour:
- Reset (synchronous, active-high):
  - Next state is IDLE.
  - Shadow register = 0, Bits_Sent = 0.
  - All outputs are 0: Ser_Valid, Ser_Data, Ser_Last, Busy, Done.
  - Reset overrides every other input, including mid-transfer; no Done is produced.
- All outputs are registered or decoded directly from state/shadow; there is no combinational path from any input to any output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Busy=0, Ser_Valid=0.
  - Start=1 at an edge: shadow <= Din, bit index <= WIDTH-1, Bits_Sent <= 0, next state SHIFT.
  - Ser_Valid is high in the cycle immediately after the accepting edge (1-cycle latency).
- SHIFT:
  - Ser_Valid=1, Ser_Data = shadow[WIDTH-1], Ser_Last = (bit index == 0).
  - A transfer occurs at an edge with Ser_Valid & Ser_Ready. On a transfer: shadow shifts left by 1 (zero fill), bit index decrements, Bits_Sent increments.
  - Ser_Valid=1 with Ser_Ready=0: Ser_Data, Ser_Last and Bits_Sent hold indefinitely.
  - A transfer with Ser_Last=1 sets next state to DONE.
  - Abort=1 at an edge: next state is IDLE, no Done. Bits_Sent keeps the count of bits accepted before the Abort. If Abort and the last transfer occur at the same edge, Abort wins: next state IDLE, the bit counts as sent, and Done is not asserted.
  - Start is ignored.
- DONE:
  - Done=1 and Busy=1 for exactly one cycle; Bits_Sent = WIDTH.
  - Next state is IDLE unconditionally.
  - Start in DONE is ignored; it must be re-asserted in IDLE.
- Throughput: with Ser_Ready held high, one bit per cycle. Start accepted at edge E gives:
  - Ser_Valid high for cycles E+1..E+WIDTH
  - Done high in cycle E+WIDTH+1
  - the earliest next Start is accepted at edge E+WIDTH+2.
- Din changes after capture have no effect on the transfer in progress.
- Bits_Sent saturates at WIDTH and never wraps.

Test Plan:
1. Reset asserted for 2 cycles with Start=1 and Din=16'hFFFF -> all outputs 0, state IDLE, Ser_Valid never rises during reset.
2. Din=16'hA5C3, Start pulse, Ser_Ready=1 -> bit stream 1010_0101_1100_0011 on cycles E+1..E+16; Ser_Last high only on cycle E+16; Done high on cycle E+17 only; Bits_Sent=16.
3. Din=16'h8001, Ser_Ready toggling 1,0,0,1,... (pseudo-random stalls) -> Ser_Data stable while stalled; received word equals 16'h8001; Done exactly once.
4. Start at E with Din=16'h1234, then Din changed to 16'hFFFF and Start re-pulsed at E+5 -> output word remains 16'h1234; the second Start is ignored; only one Done.
5. Abort asserted after 5 accepted bits of 16'hF0F0 -> next cycle IDLE, Ser_Valid=0, Bits_Sent=5, no Done; a subsequent Start with 16'h0F0F transfers cleanly.
6. Reset asserted mid-transfer (after 9 bits) -> IDLE next edge, all outputs 0, Bits_Sent=0, no Done; Abort coincident with the last transfer -> no Done, Bits_Sent=16.
